mem_port_arbiter: RTL and testbench

//   Shares the CPU's single synchronous memory port between two requesters:

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous memory port between instruction fetch (IF,
//   read-only) and data access (DM, load/store). Data accesses win a
//   simultaneous request unless IF has already been passed over STARVE_LIM
//   times in a row. Each access walks IDLE -> ACCESS -> WAIT -> RESP.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   if_req/if_addr        fetch request (level) and address
//   if_ack/if_rdata       one-cycle completion pulse and registered fetch data
//   dm_req/dm_we/dm_addr/dm_wdata
//                         data request (level), store flag, address, store data
//   dm_ack/dm_rdata       one-cycle completion pulse and registered load data
//   mem_en/mem_wen        memory enable (ACCESS only) and write enable
//   mem_addr/mem_wdata    registered address/write data to memory
//   mem_rdata             memory read data, valid in the last WAIT cycle
//   busy                  high whenever an access is in flight
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int STV_W = $clog2(STARVE_LIM + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t            state_reg, state_next;
   logic [LAT_W-1:0]  lat_cnt_reg, lat_cnt_next;
   logic [STV_W-1:0]  starve_cnt_reg, starve_cnt_next;
   logic              winner_dm_reg, winner_dm_next;
   logic              we_reg, we_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
   logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
   logic [DATA_W-1:0] dm_rdata_reg, dm_rdata_next;
   logic              grant_dm;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         lat_cnt_reg    <= '0;
         starve_cnt_reg <= '0;
         winner_dm_reg  <= 1'b0;
         we_reg         <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
         if_rdata_reg   <= '0;
         dm_rdata_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         lat_cnt_reg    <= lat_cnt_next;
         starve_cnt_reg <= starve_cnt_next;
         winner_dm_reg  <= winner_dm_next;
         we_reg         <= we_next;
         mem_addr_reg   <= mem_addr_next;
         mem_wdata_reg  <= mem_wdata_next;
         if_rdata_reg   <= if_rdata_next;
         dm_rdata_reg   <= dm_rdata_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      lat_cnt_next    = lat_cnt_reg;
      starve_cnt_next = starve_cnt_reg;
      winner_dm_next  = winner_dm_reg;
      we_next         = we_reg;
      mem_addr_next   = mem_addr_reg;
      mem_wdata_next  = mem_wdata_reg;
      if_rdata_next   = if_rdata_reg;
      dm_rdata_next   = dm_rdata_reg;
      // DM wins ties until IF has been passed over STARVE_LIM times running.
      grant_dm = dm_req && (!if_req || (starve_cnt_reg != STV_W'(STARVE_LIM)));

      case (state_reg)
         IDLE: begin
            if (dm_req || if_req) begin
               state_next     = ACCESS;
               winner_dm_next = grant_dm;
               if (grant_dm) begin
                  we_next        = dm_we;
                  mem_addr_next  = dm_addr;
                  mem_wdata_next = dm_wdata;
                  // Only a DM grant that actually bypassed a waiting IF counts.
                  if (if_req) begin
                     if (starve_cnt_reg != STV_W'(STARVE_LIM))
                        starve_cnt_next = starve_cnt_reg + 1'b1;
                  end else begin
                     starve_cnt_next = '0;
                  end
               end else begin
                  we_next         = 1'b0;
                  mem_addr_next   = if_addr;
                  starve_cnt_next = '0;
               end
            end
         end
         ACCESS: begin
            state_next   = WAIT;
            lat_cnt_next = '0;
         end
         WAIT: begin
            if (lat_cnt_reg == LAT_W'(MEM_LAT - 1)) begin
               state_next = RESP;
               // Read data is only valid on this edge; stores capture nothing.
               if (!we_reg) begin
                  if (winner_dm_reg)
                     dm_rdata_next = mem_rdata;
                  else
                     if_rdata_next = mem_rdata;
               end
            end else begin
               lat_cnt_next = lat_cnt_reg + 1'b1;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign mem_en    = (state_reg == ACCESS);
   assign mem_wen   = (state_reg == ACCESS) && we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign if_ack    = (state_reg == RESP) && !winner_dm_reg;
   assign dm_ack    = (state_reg == RESP) && winner_dm_reg;
   assign if_rdata  = if_rdata_reg;
   assign dm_rdata  = dm_rdata_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
//   Each has a small memory model that drives valid read data only in the
//   cycle MEM_LAT after the enable cycle and a junk pattern otherwise.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // instance a (MEM_LAT=1)
   logic        a_if_req, a_dm_req, a_dm_we;
   logic [31:0] a_if_addr, a_dm_addr, a_dm_wdata;
   logic        a_if_ack, a_dm_ack, a_mem_en, a_mem_wen, a_busy;
   logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   // instance b (MEM_LAT=3)
   logic        b_if_req, b_dm_req, b_dm_we;
   logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
   logic        b_if_ack, b_dm_ack, b_mem_en, b_mem_wen, b_busy;
   logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIM(4)) dut_a (
      .clk(clk), .reset(reset),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
      .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
      .dm_ack(a_dm_ack), .dm_rdata(a_dm_rdata),
      .mem_en(a_mem_en), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_LIM(4)) dut_b (
      .clk(clk), .reset(reset),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
      .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
      .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
      .mem_en(b_mem_en), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

   function automatic logic [31:0] mem_val(input logic [31:0] addr);
      case (addr)
         32'h10:  mem_val = 32'hDEAD_BEEF;
         32'h40:  mem_val = 32'hCAFE_F00D;
         32'h08:  mem_val = 32'h0000_8888;
         default: mem_val = addr ^ 32'h5A5A_0000;
      endcase
   endfunction

   // memory models: cnt loaded with MEM_LAT on a read enable edge; data valid when cnt==1
   int          a_cnt = 0, b_cnt = 0;
   logic [31:0] a_hold = '0, b_hold = '0;
   always @(posedge clk) begin
      if (a_mem_en && !a_mem_wen) begin
         a_cnt  <= 1;
         a_hold <= mem_val(a_mem_addr);
      end else if (a_cnt > 0) begin
         a_cnt <= a_cnt - 1;
      end
      if (b_mem_en && !b_mem_wen) begin
         b_cnt  <= 3;
         b_hold <= mem_val(b_mem_addr);
      end else if (b_cnt > 0) begin
         b_cnt <= b_cnt - 1;
      end
   end
   assign a_mem_rdata = (a_cnt == 1) ? a_hold : JUNK;
   assign b_mem_rdata = (b_cnt == 1) ? b_hold : JUNK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-18s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Bounded wait for an ack on instance a; timeout counts as a failure.
   task automatic wait_ack_a(output logic got_dm, output logic ok);
      ok = 1'b0;
      got_dm = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (a_if_ack || a_dm_ack) begin
            ok = 1'b1;
            got_dm = a_dm_ack;
            chk("one_ack_only", {31'b0, a_if_ack & a_dm_ack}, 32'd0);
         end
      end
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $error("FAIL ack_timeout observed=none expected=ack within 40 cycles");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       got_dm, ok;
      logic [5:0] exp_order;

      reset = 1'b1;
      a_if_req = 0; a_dm_req = 0; a_dm_we = 0;
      a_if_addr = 0; a_dm_addr = 0; a_dm_wdata = 0;
      b_if_req = 0; b_dm_req = 0; b_dm_we = 0;
      b_if_addr = 0; b_dm_addr = 0; b_dm_wdata = 0;
      step(); step(); step();

      // reset state
      chk("rst_busy", {31'b0, a_busy}, 0);
      chk("rst_mem_en", {31'b0, a_mem_en}, 0);
      chk("rst_acks", {30'b0, a_if_ack, a_dm_ack}, 0);
      chk("rst_mem_addr", a_mem_addr, 0);
      chk("rst_if_rdata", a_if_rdata, 0);
      chk("rst_dm_rdata", a_dm_rdata, 0);
      reset = 1'b0;
      step();

      // 1: single IF read
      a_if_req = 1; a_if_addr = 32'h10;                      // cycle 0
      chk("t1_c0_busy", {31'b0, a_busy}, 0);
      step();                                                // cycle 1
      chk("t1_c1_mem_en", {30'b0, a_mem_en, a_mem_wen}, 32'b10);
      chk("t1_c1_mem_addr", a_mem_addr, 32'h10);
      chk("t1_c1_busy", {31'b0, a_busy}, 1);
      step();                                                // cycle 2
      chk("t1_c2_mem_en", {31'b0, a_mem_en}, 0);
      chk("t1_c2_ack", {31'b0, a_if_ack}, 0);
      step();                                                // cycle 3
      chk("t1_c3_if_ack", {30'b0, a_if_ack, a_dm_ack}, 32'b10);
      chk("t1_c3_if_rdata", a_if_rdata, 32'hDEAD_BEEF);
      chk("t1_c3_busy", {31'b0, a_busy}, 1);
      a_if_req = 0;
      step();                                                // cycle 4
      chk("t1_c4_idle", {30'b0, a_busy, a_if_ack}, 0);

      // 2: simultaneous IF and DM load, DM first
      a_if_req = 1; a_if_addr = 32'h10;
      a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h40;         // cycle 0
      step();                                                // cycle 1
      chk("t2_c1_mem_addr", a_mem_addr, 32'h40);
      chk("t2_c1_mem_en", {31'b0, a_mem_en}, 1);
      step(); step();                                        // cycle 3
      chk("t2_c3_acks", {30'b0, a_if_ack, a_dm_ack}, 32'b01);
      chk("t2_c3_dm_rdata", a_dm_rdata, 32'hCAFE_F00D);
      a_dm_req = 0;
      step();                                                // cycle 4
      chk("t2_c4_mem_en", {31'b0, a_mem_en}, 0);
      step();                                                // cycle 5
      chk("t2_c5_mem_en", {31'b0, a_mem_en}, 1);
      chk("t2_c5_mem_addr", a_mem_addr, 32'h10);
      step(); step();                                        // cycle 7
      chk("t2_c7_acks", {30'b0, a_if_ack, a_dm_ack}, 32'b10);
      a_if_req = 0;
      step();

      // 3: both held -> D D D D I D
      exp_order = 6'b101111;
      a_if_req = 1; a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h40;
      for (int g = 0; g < 6; g++) begin
         wait_ack_a(got_dm, ok);
         if (ok) chk($sformatf("t3_grant%0d_dm", g), {31'b0, got_dm}, {31'b0, exp_order[g]});
         if (g == 5) begin
            a_if_req = 0;
            a_dm_req = 0;
         end
      end
      step(); step();
      chk("t3_idle", {31'b0, a_busy}, 0);

      // 4: store leaves dm_rdata alone
      a_dm_req = 1; a_dm_we = 1; a_dm_addr = 32'h20; a_dm_wdata = 32'h1234;  // cycle 0
      step();                                                // cycle 1
      chk("t4_c1_en_wen", {30'b0, a_mem_en, a_mem_wen}, 32'b11);
      chk("t4_c1_mem_addr", a_mem_addr, 32'h20);
      chk("t4_c1_mem_wdata", a_mem_wdata, 32'h1234);
      step();                                                // cycle 2
      chk("t4_c2_en_wen", {30'b0, a_mem_en, a_mem_wen}, 0);
      step();                                                // cycle 3
      chk("t4_c3_dm_ack", {31'b0, a_dm_ack}, 1);
      chk("t4_c3_dm_rdata", a_dm_rdata, 32'hCAFE_F00D);
      a_dm_req = 0; a_dm_we = 0;
      step();
      chk("t4_c4_hold_addr", a_mem_addr, 32'h20);

      // 5: reset during WAIT, held IF req serviced afterwards
      a_if_req = 1; a_if_addr = 32'h10;                      // cycle 0
      step(); step();                                        // cycle 2 (WAIT)
      reset = 1'b1;
      step();                                                // cycle 3
      chk("t5_rst_busy", {31'b0, a_busy}, 0);
      chk("t5_rst_acks", {30'b0, a_if_ack, a_dm_ack}, 0);
      chk("t5_rst_mem_en", {31'b0, a_mem_en}, 0);
      chk("t5_rst_mem_addr", a_mem_addr, 0);
      chk("t5_rst_if_rdata", a_if_rdata, 0);
      reset = 1'b0;
      step();                                                // cycle 4
      chk("t5_c4_mem_en", {31'b0, a_mem_en}, 1);
      chk("t5_c4_mem_addr", a_mem_addr, 32'h10);
      step();                                                // cycle 5
      chk("t5_c5_ack", {31'b0, a_if_ack}, 0);
      step();                                                // cycle 6
      chk("t5_c6_if_ack", {31'b0, a_if_ack}, 1);
      chk("t5_c6_if_rdata", a_if_rdata, 32'hDEAD_BEEF);
      a_if_req = 0;
      step();

      // 6: MEM_LAT=3, address change after grant ignored
      b_dm_req = 1; b_dm_we = 0; b_dm_addr = 32'h8;          // cycle 0
      step();                                                // cycle 1
      chk("t6_c1_mem_addr", b_mem_addr, 32'h8);
      chk("t6_c1_mem_en", {31'b0, b_mem_en}, 1);
      b_dm_addr = 32'hC;
      step(); step(); step();                                // cycle 4
      chk("t6_c4_no_ack", {31'b0, b_dm_ack}, 0);
      step();                                                // cycle 5
      chk("t6_c5_dm_ack", {31'b0, b_dm_ack}, 1);
      chk("t6_c5_dm_rdata", b_dm_rdata, 32'h0000_8888);
      chk("t6_c5_mem_addr", b_mem_addr, 32'h8);
      b_dm_req = 0;
      step();
      chk("t6_c6_idle", {31'b0, b_busy}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
